// File: rtl/mdu_ctrl_if.sv
// Handshake and data bundle between the E-stage pipeline and the MDU sequencer.
interface mdu_ctrl_if;
    logic        req;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        is_mdu_D;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDUout;

    modport master (
        output req, start, mdu_op, A, B, is_mdu_D,
        input  busy, stall, HI, LO, MDUout
    );

    modport slave (
        input  req, start, mdu_op, A, B, is_mdu_D,
        output busy, stall, HI, LO, MDUout
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO.
// Results are computed at issue and held as pending until a down-counter
// reaches its terminal count, which emulates fixed mult/div latency.
//
// state  | meaning
// S_IDLE | accepts start (mult/multu/div/divu) and mthi/mtlo
// S_BUSY | counting down; pending result commits on cnt==1
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] OP_MFHI = 4'b0100;
    localparam logic [3:0] OP_MFLO = 4'b0101;
    localparam logic [3:0] OP_MTHI = 4'b0110;
    localparam logic [3:0] OP_MTLO = 4'b0111;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [31:0]     pend_hi_q, pend_hi_d;
    logic [31:0]     pend_lo_q, pend_lo_d;
    logic            pend_wr_q, pend_wr_d;

    logic [63:0]     prod_s;
    logic [63:0]     prod_u;
    logic [31:0]     div_b;
    logic            div_ovf;
    logic [31:0]     quot_s, rem_s;
    logic [31:0]     quot_u, rem_u;
    logic            is_muldiv;
    logic            busy;

    // Arithmetic datapath; a zero or overflowing divisor is replaced by 1 so
    // the divider never sees an undefined case (div-by-zero is not committed,
    // and MIN/-1 divided by 1 gives exactly the required MIN quotient, 0 rem).
    always_comb begin
        prod_s  = $signed({{32{mdu.A[31]}}, mdu.A}) * $signed({{32{mdu.B[31]}}, mdu.B});
        prod_u  = {32'd0, mdu.A} * {32'd0, mdu.B};
        div_ovf = (mdu.A == 32'h8000_0000) && (mdu.B == 32'hFFFF_FFFF);
        div_b   = ((mdu.B == 32'd0) || div_ovf) ? 32'd1 : mdu.B;
        quot_s  = $signed(mdu.A) / $signed(div_b);
        rem_s   = $signed(mdu.A) % $signed(div_b);
        quot_u  = mdu.A / div_b;
        rem_u   = mdu.A % div_b;
    end

    assign is_muldiv = (mdu.mdu_op[3:2] == 2'b00);

    // Next-state, countdown and HI/LO update logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (!mdu.req) begin
                    if (mdu.start && is_muldiv) begin
                        state_d = S_BUSY;
                        case (mdu.mdu_op[1:0])
                            2'b00: begin
                                {pend_hi_d, pend_lo_d} = prod_s;
                                pend_wr_d = 1'b1;
                            end
                            2'b01: begin
                                {pend_hi_d, pend_lo_d} = prod_u;
                                pend_wr_d = 1'b1;
                            end
                            2'b10: begin
                                pend_hi_d = rem_s;
                                pend_lo_d = quot_s;
                                pend_wr_d = (mdu.B != 32'd0);
                            end
                            default: begin
                                pend_hi_d = rem_u;
                                pend_lo_d = quot_u;
                                pend_wr_d = (mdu.B != 32'd0);
                            end
                        endcase
                        cnt_d = mdu.mdu_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    end else if (mdu.mdu_op == OP_MTHI) begin
                        hi_d = mdu.A;
                    end else if (mdu.mdu_op == OP_MTLO) begin
                        lo_d = mdu.A;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and architectural register update; reset aborts any op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign mdu.busy  = busy;
    assign mdu.stall = mdu.is_mdu_D & (busy | mdu.start);
    assign mdu.HI    = hi_q;
    assign mdu.LO    = lo_q;

    // mfhi/mflo read path, combinational on the E-stage op.
    always_comb begin
        mdu.MDUout = 32'd0;
        if (mdu.mdu_op == OP_MFHI) begin
            mdu.MDUout = hi_q;
        end else if (mdu.mdu_op == OP_MFLO) begin
            mdu.MDUout = lo_q;
        end
    end

endmodule
